// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and its golden detect model.
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10
  } state_t;

  localparam int                 DET_LEN  = 3;
  localparam logic [DET_LEN-1:0] DET_PAT  = 3'b011;
  localparam logic [DET_LEN-1:0] HIST_RST = 3'b111;

endpackage

// File: rtl/seq_ref_model.sv
// History shift register plus compare; flags every (overlapping) occurrence of DET
// in the last DET_W serial values, oldest bit in the MSB.
module seq_ref_model
  import seq_pkg::*;
#(
  parameter int               DET_W = DET_LEN,
  parameter logic [DET_W-1:0] DET   = DET_PAT,
  parameter logic [DET_W-1:0] RST   = HIST_RST
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_in,
  output logic match
);

  logic [DET_W-1:0] hist_q;

  // NOTE: sequential state is always written with non-blocking assignments so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= RST;
    else        hist_q <= {hist_q[DET_W-2:0], bit_in};
  end

  assign match = (hist_q == DET);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern generator: shifts a loaded pattern out MSB-first with repeats and
// idle gaps, plus a golden "011" detect flag aligned with a Moore detector.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter  int   PAT_W    = 8,
  parameter  int   REP_W    = 4,
  parameter  int   GAP      = 2,
  parameter  logic IDLE_BIT = 1'b1,
  localparam int   LEN_W    = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic [REP_W-1:0] rep_in,
  output logic             ready,
  output logic             busy,
  output logic             x_out,
  output logic             x_valid,
  output logic             done,
  output logic             exp_det
);

  localparam int               GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;    // captured pattern, first bit aligned to the MSB
  logic [PAT_W-1:0] sh_q, sh_d;      // working copy, shifted left as bits go out
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bitcnt_q, bitcnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gapcnt_q, gapcnt_d;
  logic             x_d, valid_d, done_d;

  logic [LEN_W-1:0] len_clamp;
  logic [PAT_W-1:0] pat_align;
  logic             last_bit;
  logic             reload;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d  = state_q;
    pat_d    = pat_q;
    sh_d     = sh_q;
    len_d    = len_q;
    bitcnt_d = bitcnt_q;
    rep_d    = rep_q;
    gapcnt_d = gapcnt_q;
    x_d      = IDLE_BIT;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    reload   = 1'b0;

    len_clamp = (len_in > LEN_MAX) ? LEN_MAX : len_in;
    pat_align = pat_in << (LEN_MAX - len_clamp);
    last_bit  = (bitcnt_q == len_q - LEN_W'(1));

    case (state_q)
      S_IDLE: begin
        if (start && len_clamp != '0) begin
          state_d  = S_SHIFT;
          pat_d    = pat_align;
          len_d    = len_clamp;
          rep_d    = rep_in;
          bitcnt_d = '0;
          x_d      = pat_align[PAT_W-1];
          sh_d     = pat_align << 1;
          valid_d  = 1'b1;
          done_d   = (len_clamp == LEN_W'(1)) && (rep_in == '0);
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!last_bit) begin
          bitcnt_d = bitcnt_q + LEN_W'(1);
          x_d      = sh_q[PAT_W-1];
          sh_d     = sh_q << 1;
          valid_d  = 1'b1;
          done_d   = (bitcnt_d == len_q - LEN_W'(1)) && (rep_q == '0);
        end else if (rep_q == '0) begin
          state_d = S_IDLE;
        end else begin
          rep_d = rep_q - REP_W'(1);
          if (GAP > 0) begin
            state_d  = S_GAP;
            gapcnt_d = '0;
          end else begin
            reload = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (abort)                              state_d  = S_IDLE;
        else if (gapcnt_q == GAP_W'(GAP - 1))   reload   = 1'b1;
        else                                    gapcnt_d = gapcnt_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Start of a repeat pass from the captured pattern.
    if (reload) begin
      state_d  = S_SHIFT;
      bitcnt_d = '0;
      x_d      = pat_q[PAT_W-1];
      sh_d     = pat_q << 1;
      valid_d  = 1'b1;
      done_d   = (len_q == LEN_W'(1)) && (rep_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      sh_q     <= '0;
      len_q    <= '0;
      bitcnt_q <= '0;
      rep_q    <= '0;
      gapcnt_q <= '0;
      x_out    <= IDLE_BIT;
      x_valid  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      sh_q     <= sh_d;
      len_q    <= len_d;
      bitcnt_q <= bitcnt_d;
      rep_q    <= rep_d;
      gapcnt_q <= gapcnt_d;
      x_out    <= x_d;
      x_valid  <= valid_d;
      done     <= done_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_SHIFT) || (state_q == S_GAP);

  seq_ref_model u_ref (
    .clk    (clk),
    .rst_n  (rst_n),
    .bit_in (x_out),
    .match  (exp_det)
  );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed and random transfers compared
// cycle by cycle against an expected-stream model built from the transfer rules.
module tb_seq_pattern_tx;

  localparam int PAT_W = 8;
  localparam int REP_W = 4;
  localparam int GAP_P = 2;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] pat_in = '0;
  logic [LEN_W-1:0] len_in = '0;
  logic [REP_W-1:0] rep_in = '0;
  logic             ready, busy, x_out, x_valid, done, exp_det;

  int checks = 0;
  int failures = 0;
  int cyc_no = 0;

  typedef struct packed {
    logic x;
    logic v;
    logic b;
    logic d;
  } exp_t;

  localparam exp_t IDLE_E = '{x: 1'b1, v: 1'b0, b: 1'b0, d: 1'b0};

  // Every expected x_out value since the last reset, seeded with the reset history.
  logic xh[$];

  seq_pattern_tx #(
    .PAT_W    (PAT_W),
    .REP_W    (REP_W),
    .GAP      (GAP_P),
    .IDLE_BIT (1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .pat_in  (pat_in),
    .len_in  (len_in),
    .rep_in  (rep_in),
    .ready   (ready),
    .busy    (busy),
    .x_out   (x_out),
    .x_valid (x_valid),
    .done    (done),
    .exp_det (exp_det)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc_no, obs, exp_v);
    end
  endtask

  // One clock cycle: outputs are sampled at the falling edge.
  task automatic cyc(input exp_t e);
    logic edet;
    int n;
    @(negedge clk);
    cyc_no++;
    n    = xh.size();
    edet = (xh[n-3] == 1'b0) && (xh[n-2] == 1'b1) && (xh[n-1] == 1'b1);
    chk("x_out",   x_out,   e.x);
    chk("x_valid", x_valid, e.v);
    chk("busy",    busy,    e.b);
    chk("ready",   ready,   ~e.b);
    chk("done",    done,    e.d);
    chk("exp_det", exp_det, edet);
    xh.push_back(e.x);
    if (xh.size() > 8) void'(xh.pop_front());
  endtask

  task automatic do_reset();
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_x_out",   x_out,   1'b1);
    chk("rst_x_valid", x_valid, 1'b0);
    chk("rst_done",    done,    1'b0);
    chk("rst_busy",    busy,    1'b0);
    chk("rst_ready",   ready,   1'b1);
    chk("rst_exp_det", exp_det, 1'b0);
    xh = '{1'b1, 1'b1, 1'b1};
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transfer request, started from a falling edge while IDLE.
  // abort_at / rst_at: index of the expected cycle after which abort / reset is applied.
  task automatic run(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len_req,
                     input logic [REP_W-1:0] rep, input int abort_at, input int rst_at,
                     input bit mid_start, input bit start_abort);
    exp_t q[$];
    int   len;
    len = (int'(len_req) > PAT_W) ? PAT_W : int'(len_req);
    if (len > 0) begin
      for (int p = 0; p <= int'(rep); p++) begin
        for (int i = 0; i < len; i++)
          q.push_back(exp_t'{x: pat[len-1-i], v: 1'b1, b: 1'b1,
                             d: (p == int'(rep)) && (i == len - 1)});
        if (p < int'(rep))
          for (int g = 0; g < GAP_P; g++) q.push_back(IDLE_E | exp_t'{x: 1'b1, v: 1'b0, b: 1'b1, d: 1'b0});
      end
    end
    pat_in = pat;
    len_in = len_req;
    rep_in = rep;
    start  = 1'b1;
    abort  = start_abort;
    if (q.size() == 0) begin
      cyc(IDLE_E);
      start = 1'b0;
      abort = 1'b0;
      return;
    end
    foreach (q[i]) begin
      cyc(q[i]);
      if (i == rst_at) begin
        do_reset();
        return;
      end
      start = mid_start && (i == 1);
      if (start) begin
        pat_in = PAT_W'($urandom);
        len_in = LEN_W'($urandom_range(1, PAT_W));
        rep_in = REP_W'($urandom);
      end
      abort = (i == abort_at);
      if (abort) break;
    end
    start = 1'b0;
    cyc(IDLE_E);
    abort = 1'b0;
  endtask

  initial begin
    logic [PAT_W-1:0] rp;
    logic [LEN_W-1:0] rl;
    logic [REP_W-1:0] rr;
    int               ra;

    #2;
    do_reset();

    run(8'b0000_0011, 3, 0, -1, -1, 1'b0, 1'b0);
    run(8'b0011_0110, 7, 0, -1, -1, 1'b0, 1'b0);
    run(8'b0000_0011, 3, 2, -1, -1, 1'b0, 1'b0);
    // Start while busy is ignored; abort during bit index 2.
    run(8'b1101_1011, 8, 1, 2, -1, 1'b1, 1'b0);
    // Abort during a gap cycle.
    run(8'b0000_0011, 3, 1, 4, -1, 1'b0, 1'b0);
    run(8'h5A, 0, 2, -1, -1, 1'b0, 1'b0);
    run(8'hA5, 8, 0, -1, -1, 1'b0, 1'b0);
    run(8'h3C, 12, 1, -1, -1, 1'b0, 1'b0);
    run(8'h01, 1, 2, -1, -1, 1'b0, 1'b0);
    // Abort alone in IDLE does nothing; start together with abort wins.
    abort = 1'b1;
    cyc(IDLE_E);
    abort = 1'b0;
    run(8'b0000_1011, 4, 1, -1, -1, 1'b0, 1'b1);
    // Asynchronous reset mid-SHIFT, then a clean repeat of the first transfer.
    run(8'hFF, 8, 0, -1, 3, 1'b0, 1'b0);
    run(8'b0000_0011, 3, 0, -1, -1, 1'b0, 1'b0);

    repeat (30) begin
      rp = PAT_W'($urandom);
      rl = LEN_W'($urandom_range(0, 12));
      rr = REP_W'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
      run(rp, rl, rr, ra, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
